hazard_detect_unit: RTL and testbench

- Combinational pipeline-hazard detector for the 5-stage PoliRISC-V core; sits beside the ID/EX/MEM stage registers.
- Compares ID-stage source registers against EX/MEM destination registers and produces IF/ID stall and ID/EX flush controls, selected by a decoder-supplied hazard class.
- Also holds a registered stall-cycle performance counter, the only clocked logic in the block.

---
 rtl/hazard_detect_unit.sv | 89 ++++++++
 tb/tb_hazard_detect_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_detect_unit.sv
// Pipeline hazard detector for the 5-stage core: combinational stall/flush controls
// selected by the decoder's hazard class, plus a saturating stall-cycle counter.
package hazard_unit_pkg;
    typedef enum logic [1:0] {
        NoHazard        = 2'd0,
        HazardDecode    = 2'd1,
        HazardExecute   = 2'd2,
        HazardException = 2'd3
    } hazard_t;
endpackage

module hazard_detect_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  hazard_unit_pkg::hazard_t  hazard_type,
    input  logic                      rs_used,
    input  logic [4:0]                rs1_id,
    input  logic [4:0]                rs2_id,
    input  logic [4:0]                rd_ex,
    input  logic [4:0]                rd_mem,
    input  logic                      reg_we_ex,
    input  logic                      reg_we_mem,
    input  logic                      mem_rd_en_ex,
    input  logic                      mem_rd_en_mem,
    input  logic                      store_id,
    input  logic                      zicsr_ex,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      flush_id,
    output logic                      flush_ex,
    output logic [CNT_WIDTH-1:0]      stall_count
);
    import hazard_unit_pkg::*;

    // x0 is hardwired zero, so a write to it never creates a dependency
    function automatic logic f_match(input logic [4:0] rs, input logic [4:0] rd,
                                     input logic we, input logic en);
        return (rs == rd) && (rd != 5'd0) && we && en;
    endfunction

    logic w_h1_dec, w_h2_dec, w_h1_exe, w_h2_exe;
    logic w_stall;
    logic w_unused;

    // Reserved decoder hints, kept on the port list for interface stability
    assign w_unused = rs_used ^ store_id;

    assign w_h1_dec = f_match(rs1_id, rd_ex,  reg_we_ex,  !zicsr_ex)
                   || f_match(rs1_id, rd_mem, reg_we_mem, mem_rd_en_mem);
    assign w_h2_dec = f_match(rs2_id, rd_ex,  reg_we_ex,  1'b1)
                   || f_match(rs2_id, rd_mem, reg_we_mem, mem_rd_en_mem);
    assign w_h1_exe = f_match(rs1_id, rd_ex,  reg_we_ex,  mem_rd_en_ex);
    assign w_h2_exe = f_match(rs2_id, rd_ex,  reg_we_ex,  mem_rd_en_ex && !zicsr_ex);

    always_comb begin
        w_stall  = 1'b0;
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        case (hazard_type)
            HazardDecode:    w_stall = w_h1_dec || w_h2_dec;
            HazardExecute:   w_stall = w_h1_exe || w_h2_exe;
            HazardException: begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end
            default:         w_stall = 1'b0;
        endcase
        if (w_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    logic [CNT_WIDTH-1:0] r_stall_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_stall_count <= '0;
        else if (stall_if && (r_stall_count != {CNT_WIDTH{1'b1}}))
            r_stall_count <= r_stall_count + 1'b1;
    end

    assign stall_count = r_stall_count;
endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench for hazard_detect_unit: directed cases, randomized vectors
// against a rule-level reference model, and stall counter behaviour.
module tb_hazard_detect_unit;
    import hazard_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    hazard_t     hazard_type;
    logic        rs_used, store_id;
    logic [4:0]  rs1_id, rs2_id, rd_ex, rd_mem;
    logic        reg_we_ex, reg_we_mem, mem_rd_en_ex, mem_rd_en_mem, zicsr_ex;
    logic        stall_if, stall_id, flush_id, flush_ex;
    logic        s_stall_if, s_stall_id, s_flush_id, s_flush_ex;
    logic [31:0] stall_count;
    logic [2:0]  sat_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    hazard_detect_unit #(.CNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .hazard_type(hazard_type), .rs_used(rs_used),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex), .rd_mem(rd_mem),
        .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem), .mem_rd_en_ex(mem_rd_en_ex),
        .mem_rd_en_mem(mem_rd_en_mem), .store_id(store_id), .zicsr_ex(zicsr_ex),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
        .stall_count(stall_count)
    );

    // Narrow counter instance so saturation is reachable in a few cycles
    hazard_detect_unit #(.CNT_WIDTH(3)) dut_sat (
        .clock(clock), .reset(reset), .hazard_type(hazard_type), .rs_used(rs_used),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex), .rd_mem(rd_mem),
        .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem), .mem_rd_en_ex(mem_rd_en_ex),
        .mem_rd_en_mem(mem_rd_en_mem), .store_id(store_id), .zicsr_ex(zicsr_ex),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .flush_id(s_flush_id), .flush_ex(s_flush_ex),
        .stall_count(sat_count)
    );

    wire [3:0] ctrl = {stall_if, stall_id, flush_id, flush_ex};

    // Reference: {stall_if, stall_id, flush_id, flush_ex}
    function automatic logic [3:0] ref_ctrl(input hazard_t ht, input logic [4:0] r1, r2, dex, dmem,
                                            input logic wex, wmem, lex, lmem, zc);
        bit dep1_ex, dep2_ex, dep1_mem, dep2_mem, hz;
        dep1_ex  = (r1 == dex)  && (dex != 0)  && wex;
        dep2_ex  = (r2 == dex)  && (dex != 0)  && wex;
        dep1_mem = (r1 == dmem) && (dmem != 0) && wmem;
        dep2_mem = (r2 == dmem) && (dmem != 0) && wmem;
        hz = 0;
        if (ht == HazardException) return 4'b0011;
        if (ht == HazardDecode)
            hz = (dep1_ex && !zc) || (dep1_mem && lmem) || dep2_ex || (dep2_mem && lmem);
        else if (ht == HazardExecute)
            hz = (dep1_ex && lex) || (dep2_ex && lex && !zc);
        return hz ? 4'b1101 : 4'b0000;
    endfunction

    task automatic drive(input hazard_t ht, input logic [4:0] r1, r2, dex, dmem,
                         input logic wex, wmem, lex, lmem, zc);
        hazard_type = ht; rs1_id = r1; rs2_id = r2; rd_ex = dex; rd_mem = dmem;
        reg_we_ex = wex; reg_we_mem = wmem; mem_rd_en_ex = lex; mem_rd_en_mem = lmem;
        zicsr_ex = zc;
    endtask

    task automatic test_reset;
        drive(NoHazard, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rs_used = 0; store_id = 0;
        reset = 1;
        repeat (2) @(negedge clock);
        total_cnt++;
        if (stall_count !== 32'd0) $display("FAIL reset_count got %0d want 0", stall_count);
        else pass_cnt++;
        total_cnt++;
        if (ctrl !== 4'b0000) $display("FAIL reset_ctrl got %b want 0000", ctrl);
        else pass_cnt++;
        reset = 0;
    endtask

    task automatic test_decode;
        drive(HazardDecode, 5, 0, 5, 0, 1, 0, 0, 0, 0); #1;
        total_cnt++;
        if (ctrl !== 4'b1101) $display("FAIL dec_rs1_ex got %b want 1101", ctrl); else pass_cnt++;
        drive(HazardDecode, 5, 0, 5, 7, 1, 0, 0, 0, 1); #1;
        total_cnt++;
        if (ctrl !== 4'b0000) $display("FAIL dec_rs1_zicsr got %b want 0000", ctrl); else pass_cnt++;
        drive(HazardDecode, 0, 9, 0, 9, 0, 1, 0, 1, 0); #1;
        total_cnt++;
        if (ctrl !== 4'b1101) $display("FAIL dec_rs2_mem_load got %b want 1101", ctrl); else pass_cnt++;
        drive(HazardDecode, 0, 9, 0, 9, 0, 1, 0, 0, 0); #1;
        total_cnt++;
        if (ctrl !== 4'b0000) $display("FAIL dec_rs2_mem_noload got %b want 0000", ctrl); else pass_cnt++;
        drive(HazardDecode, 0, 0, 0, 0, 1, 1, 1, 1, 0); #1;
        total_cnt++;
        if (ctrl !== 4'b0000) $display("FAIL dec_x0 got %b want 0000", ctrl); else pass_cnt++;
    endtask

    task automatic test_execute;
        drive(HazardExecute, 3, 0, 3, 0, 1, 0, 1, 0, 0); #1;
        total_cnt++;
        if (ctrl !== 4'b1101) $display("FAIL exe_rs1_load got %b want 1101", ctrl); else pass_cnt++;
        drive(HazardExecute, 3, 0, 3, 0, 1, 0, 0, 0, 0); #1;
        total_cnt++;
        if (ctrl !== 4'b0000) $display("FAIL exe_rs1_noload got %b want 0000", ctrl); else pass_cnt++;
        drive(HazardExecute, 0, 3, 3, 0, 1, 0, 1, 0, 1); #1;
        total_cnt++;
        if (ctrl !== 4'b0000) $display("FAIL exe_rs2_zicsr got %b want 0000", ctrl); else pass_cnt++;
        drive(HazardExecute, 0, 3, 3, 0, 1, 0, 1, 0, 0); #1;
        total_cnt++;
        if (ctrl !== 4'b1101) $display("FAIL exe_rs2_load got %b want 1101", ctrl); else pass_cnt++;
    endtask

    task automatic test_exception_nohazard;
        for (int i = 0; i < 8; i++) begin
            drive(HazardException, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)); #1;
            total_cnt++;
            if (ctrl !== 4'b0011) $display("FAIL exception_%0d got %b want 0011", i, ctrl);
            else pass_cnt++;
        end
        drive(NoHazard, 4, 4, 4, 4, 1, 1, 1, 1, 0); #1;
        total_cnt++;
        if (ctrl !== 4'b0000) $display("FAIL nohazard_match got %b want 0000", ctrl); else pass_cnt++;
    endtask

    task automatic test_random;
        logic [3:0] exp;
        int errs = 0;
        for (int i = 0; i < 10000; i++) begin
            // Small register range so matches are frequent
            drive(hazard_t'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            exp = ref_ctrl(hazard_type, rs1_id, rs2_id, rd_ex, rd_mem, reg_we_ex, reg_we_mem,
                           mem_rd_en_ex, mem_rd_en_mem, zicsr_ex);
            for (int k = 0; k < 2; k++) begin
                rs_used = 1'($urandom); store_id = 1'($urandom); #1;
                total_cnt++;
                if (ctrl !== exp) begin
                    if (errs < 10)
                        $display("FAIL random_%0d ht=%0d rs1=%0d rs2=%0d rdex=%0d rdmem=%0d got %b want %b",
                                 i, hazard_type, rs1_id, rs2_id, rd_ex, rd_mem, ctrl, exp);
                    errs++;
                end else pass_cnt++;
            end
        end
        rs_used = 0; store_id = 0;
    endtask

    task automatic test_stall_count;
        @(negedge clock);
        drive(NoHazard, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        @(negedge clock);
        reset = 0;
        drive(HazardDecode, 5, 0, 5, 0, 1, 0, 0, 0, 0);
        repeat (4) @(negedge clock);
        drive(NoHazard, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (stall_count !== 32'd4) $display("FAIL count_4 got %0d want 4", stall_count); else pass_cnt++;
        repeat (3) @(negedge clock);
        total_cnt++;
        if (stall_count !== 32'd4) $display("FAIL count_hold got %0d want 4", stall_count); else pass_cnt++;
        drive(HazardDecode, 5, 0, 5, 0, 1, 0, 0, 0, 0);
        repeat (6) @(negedge clock);
        drive(NoHazard, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (stall_count !== 32'd10) $display("FAIL count_10 got %0d want 10", stall_count); else pass_cnt++;
        total_cnt++;
        if (sat_count !== 3'd7) $display("FAIL count_saturate got %0d want 7", sat_count); else pass_cnt++;
        // Reset asserted between edges must clear without waiting for a clock
        #2 reset = 1;
        #1;
        total_cnt++;
        if (stall_count !== 32'd0) $display("FAIL async_reset got %0d want 0", stall_count); else pass_cnt++;
        total_cnt++;
        if (sat_count !== 3'd0) $display("FAIL async_reset_sat got %0d want 0", sat_count); else pass_cnt++;
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_execute();
        test_exception_nohazard();
        test_random();
        test_stall_count();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
